// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for the 4-input registered mux: one-hot grant, mux select,
// per-tenure burst cap and an out_valid aligned with the mux output register.
module mux4_rr_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       out_valid
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BURST_LIM = CW'(BURST_MAX);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [1:0]    ptr_r;
  logic [1:0]    ptr_nxt_s;
  logic [1:0]    holder_r;
  logic [1:0]    holder_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          release_s;
  logic [3:0]    grant_nxt_s;
  logic [1:0]    sel_nxt_s;
  logic          busy_nxt_s;

  // First set bit of r searched upward from p, wrapping 3 -> 0.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  assign release_s = !req[holder_r] || (cnt_r >= BURST_LIM);

  // State and arbitration registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      ptr_r    <= 2'd0;
      holder_r <= 2'd0;
      cnt_r    <= CNT_ZERO;
    end else begin
      state_r  <= state_nxt_s;
      ptr_r    <= ptr_nxt_s;
      holder_r <= holder_nxt_s;
      cnt_r    <= cnt_nxt_s;
    end
  end

  // Next-state and arbitration decision.
  always_comb begin
    state_nxt_s  = state_r;
    ptr_nxt_s    = ptr_r;
    holder_nxt_s = holder_r;
    cnt_nxt_s    = cnt_r;
    case (state_r)
      IDLE: begin
        if (req != 4'b0000) begin
          state_nxt_s  = GRANT;
          holder_nxt_s = pick(req, ptr_r);
          cnt_nxt_s    = CNT_ONE;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      GRANT: begin
        if (!release_s) begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
          // The pointer moves past the releasing holder before re-arbitrating,
          // so a lone holder at its burst limit is simply re-granted.
          ptr_nxt_s = holder_r + 2'd1;
          if (req != 4'b0000) begin
            state_nxt_s  = GRANT;
            holder_nxt_s = pick(req, holder_r + 2'd1);
            cnt_nxt_s    = CNT_ONE;
          end else begin
            state_nxt_s  = IDLE;
            cnt_nxt_s    = CNT_ZERO;
          end
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        ptr_nxt_s    = 2'd0;
        holder_nxt_s = 2'd0;
        cnt_nxt_s    = CNT_ZERO;
      end
    endcase
  end

  // Output values for the next cycle; sel holds its last value when idle.
  always_comb begin
    grant_nxt_s = 4'b0000;
    sel_nxt_s   = sel;
    busy_nxt_s  = 1'b0;
    if (state_nxt_s == GRANT) begin
      grant_nxt_s = onehot(holder_nxt_s);
      sel_nxt_s   = holder_nxt_s;
      busy_nxt_s  = 1'b1;
    end else begin
      grant_nxt_s = 4'b0000;
      sel_nxt_s   = sel;
      busy_nxt_s  = 1'b0;
    end
  end

  // Registered outputs; out_valid trails busy to match the mux output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant     <= 4'b0000;
      sel       <= 2'd0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      grant     <= grant_nxt_s;
      sel       <= sel_nxt_s;
      busy      <= busy_nxt_s;
      out_valid <= busy;
    end
  end

  mux4_rr_arbiter_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .grant     (grant),
    .sel       (sel),
    .busy      (busy),
    .out_valid (out_valid)
  );

endmodule

// Output invariants of the arbiter.
module mux4_rr_arbiter_chk (
  input logic       clk,
  input logic       rst,
  input logic [3:0] grant,
  input logic [1:0] sel,
  input logic       busy,
  input logic       out_valid
);

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(grant));

  a_sel_with_grant: assert property (@(posedge clk) disable iff (!rst)
    (sel != $past(sel)) |-> (grant != $past(grant)));

  a_busy_matches_grant: assert property (@(posedge clk) disable iff (!rst)
    busy == (grant != 4'b0000));

  a_out_valid_delay: assert property (@(posedge clk) disable iff (!rst)
    out_valid == $past(busy));

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomised and directed checks of mux4_rr_arbiter against a behavioural
// round-robin model.
module tb_mux4_rr_arbiter;

  localparam int BM = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       out_valid;

  int n_cmp;
  int n_fail;

  // Reference model state
  bit         m_active;
  int         m_ptr;
  int         m_holder;
  int         m_cnt;
  logic [3:0] m_grant;
  logic [1:0] m_sel;
  logic       m_busy;
  logic       m_ov;

  mux4_rr_arbiter #(.BURST_MAX(BM)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .grant     (grant),
    .sel       (sel),
    .busy      (busy),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_ptr = 0;
    m_holder = 0;
    m_cnt = 0;
    m_grant = 4'b0000;
    m_sel = 2'd0;
    m_busy = 1'b0;
    m_ov = 1'b0;
  endtask

  task automatic model_update(input logic [3:0] r);
    int h;
    m_ov = m_busy;
    if (!m_active) begin
      h = m_pick(r, m_ptr);
      if (h >= 0) begin
        m_active = 1'b1;
        m_holder = h;
        m_cnt = 1;
      end
    end else if (r[m_holder] && m_cnt < BM) begin
      m_cnt = m_cnt + 1;
    end else begin
      m_ptr = (m_holder + 1) % 4;
      h = m_pick(r, m_ptr);
      if (h >= 0) begin
        m_holder = h;
        m_cnt = 1;
      end else begin
        m_active = 1'b0;
      end
    end
    if (m_active) begin
      m_grant = 4'b0001 << m_holder;
      m_sel = 2'(m_holder);
    end
    else m_grant = 4'b0000;
    m_busy = m_active;
  endtask

  // Called at a negedge: drive req, let one rising edge pass, return at next negedge.
  task automatic tick(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_update(r);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 4'b1111;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({grant, sel, busy, out_valid} !== 8'b0000_00_0_0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got g=%b s=%b b=%b v=%b, want all zero",
                 i, grant, sel, busy, out_valid);
      end
    end
    rst = 1'b1;
    tick(4'b1111);
    n_cmp++;
    if (grant !== 4'b0001 || sel !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: got g=%b s=%b, want g=0001 s=00", grant, sel);
    end
  endtask

  task automatic test_single();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      tick(4'b0100);
      n_cmp++;
      if (grant !== 4'b0100 || sel !== 2'b10 || busy !== 1'b1 || out_valid !== (i >= 1)) begin
        n_fail++;
        $display("FAIL single[%0d]: got g=%b s=%b b=%b v=%b, want g=0100 s=10 b=1 v=%0d",
                 i, grant, sel, busy, out_valid, (i >= 1));
      end
    end
  endtask

  task automatic test_contention();
    logic [3:0] e;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      tick(4'b1111);
      e = 4'b0001 << ((i / 4) % 4);
      n_cmp++;
      if (grant !== e || sel !== 2'((i / 4) % 4) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL contention[%0d]: got g=%b s=%b b=%b, want g=%b s=%0d b=1",
                 i, grant, sel, busy, e, (i / 4) % 4);
      end
    end
  endtask

  task automatic test_early_release();
    apply_reset();
    tick(4'b0011);
    tick(4'b0011);
    n_cmp++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL early_pre: got g=%b, want 0001", grant);
    end
    for (int i = 0; i < 6; i++) begin
      tick(4'b0010);
      n_cmp++;
      if (grant !== 4'b0010 || sel !== 2'b01 || {grant, sel, busy, out_valid} !== {m_grant, m_sel, m_busy, m_ov}) begin
        n_fail++;
        $display("FAIL early_release[%0d]: got g=%b s=%b b=%b v=%b, want g=0010 s=01 b=%b v=%b",
                 i, grant, sel, busy, out_valid, m_busy, m_ov);
      end
    end
  endtask

  task automatic test_idle_return();
    apply_reset();
    tick(4'b1000);
    tick(4'b1000);
    tick(4'b0000);
    n_cmp++;
    if (grant !== 4'b0000 || busy !== 1'b0 || sel !== 2'b11 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_return: got g=%b s=%b b=%b v=%b, want g=0000 s=11 b=0 v=1",
               grant, sel, busy, out_valid);
    end
    tick(4'b0000);
    n_cmp++;
    if (out_valid !== 1'b0 || sel !== 2'b11) begin
      n_fail++;
      $display("FAIL idle_valid: got v=%b s=%b, want v=0 s=11", out_valid, sel);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 10; i++) tick(4'b1111);
    n_cmp++;
    if (grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_pre: got g=%b, want 0100", grant);
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({grant, sel, busy, out_valid} !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL mid_reset: got g=%b s=%b b=%b v=%b, want all zero",
               grant, sel, busy, out_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    tick(4'b1111);
    n_cmp++;
    if (grant !== 4'b0001 || sel !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_restart: got g=%b s=%b, want g=0001 s=00", grant, sel);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    apply_reset();
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 2) begin
        rst = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({grant, sel, busy, out_valid} !== 8'b0000_00_0_0) begin
          n_fail++;
          $display("FAIL random_reset[%0d]: got g=%b s=%b b=%b v=%b, want all zero",
                   i, grant, sel, busy, out_valid);
        end
        @(negedge clk);
        rst = 1'b1;
      end
      if ($urandom_range(99) < 30) r = 4'($urandom);
      tick(r);
      n_cmp++;
      if ({grant, sel, busy, out_valid} !== {m_grant, m_sel, m_busy, m_ov}) begin
        n_fail++;
        $display("FAIL random[%0d] req=%b: got g=%b s=%b b=%b v=%b, want g=%b s=%b b=%b v=%b",
                 i, r, grant, sel, busy, out_valid, m_grant, m_sel, m_busy, m_ov);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b0;
    req = 4'b0000;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_idle_return();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer for the 4-input registered mux datapath. Four requesters compete for the mux output. The block grants one requester at a time, drives the mux `sel` accordingly, and caps each tenure at a programmable number of cycles. It also produces `out_valid`, which is aligned with the mux's registered output one cycle after the grant.

## Interface
- `BURST_MAX`, default 4: maximum consecutive cycles a single grant may last. Legal range is 1..15; 0 is illegal.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous reset, active-low. Asserting `rst`=0 forces the reset state immediately.
- `req`  in  4: request vector. Bit i is requester i (mux input in(i+1)) and is level-sensitive.
- `grant`  out  4: one-hot grant, registered. All zeros when idle.
- `sel`  out  2: mux select, registered. Equals the index of the granted bit, and holds its last value when idle.
- `busy`  out  1: registered. 1 while any grant is active (`|grant`).
- `out_valid`  out  1: registered. It is `busy` delayed by one cycle, marking the cycle the mux register holds the granted input.

## Operation
- State is IDLE or GRANT, plus the following registers:
  - `ptr[1:0]`: round-robin start index.
  - `holder[1:0]`: index of the current grant.
  - `cnt`: tenure counter, `$clog2(BURST_MAX+1)` bits.
- Reset values: state=IDLE, `grant`=0000, `sel`=00, `busy`=0, `out_valid`=0, `ptr`=0, `cnt`=0.
- Pick function: the first set bit of `req` searched from `ptr` upward, wrapping 3→0.
- IDLE:
  - If `req`=0000, stay in IDLE.
  - Otherwise at the next edge: `holder`=pick, `grant`=onehot(pick), `sel`=pick, `cnt`=1, state=GRANT.
- GRANT, evaluated each edge:
  - Hold condition: `req[holder]`=1 and `cnt`<`BURST_MAX`. Grant is unchanged and `cnt`++.
  - Release condition: `req[holder]`=0 or `cnt`=`BURST_MAX`. Set `ptr`=`holder`+1 (mod 4), then arbitrate with the pick function using the updated `ptr`.
    - If a requester is found, grant it at this same edge with no idle cycle and set `cnt`=1.
    - If none is found, go to IDLE with `grant`=0000 and `sel` unchanged.
- On a burst-limit release where the holder is the only requester, the holder is re-granted for a new tenure. The grant stays continuous and `cnt` restarts at 1.
- Simultaneous requests are resolved purely by the pick function; there is no fixed priority.
- A request that drops while not granted is simply not picked, and no state is kept for it.
- A `rst` assertion mid-tenure immediately clears all outputs and `ptr`, asynchronously. After release the block restarts from IDLE with `ptr`=0.

## Timing
- Request-to-grant latency is 1 cycle: `req` is sampled at edge n and `grant`/`sel` are valid after edge n.
- `out_valid` follows `busy` by exactly 1 cycle, which matches the mux output register latency.
- Maximum continuous tenure is `BURST_MAX` cycles.
- Worst-case wait for a continuously requesting input is 3×`BURST_MAX` cycles after the first grant elsewhere.
- When the holder drops `req` at edge n, its grant is removed at edge n. The next grant starts at edge n if another request is present.
- `grant` is always one-hot or zero, and `sel` changes only together with `grant`. Both properties are checkable as assertions.

## Test plan
- Reset: hold `rst`=0 with `req`=1111 for 3 cycles. Expect `grant`=0000, `sel`=00, `busy`=0, `out_valid`=0 throughout. Release `rst`; one edge later expect `grant`=0001 and `sel`=00.
- Single requester, `BURST_MAX`=4: apply `req`=0100 for 12 cycles. Expect `grant`=0100 and `sel`=10 continuously from 1 cycle after `req`, with `out_valid`=1 from 2 cycles after `req`.
- Full contention, `BURST_MAX`=4: apply `req`=1111 continuously. Expect `grant` to cycle 0001→0010→0100→1000→0001, each for exactly 4 cycles, with `sel` 00→01→10→11→00 and no gaps.
- Early release: apply `req`=0011. After `grant`=0001 has lasted 2 cycles, drop `req[0]`. At that same edge expect `grant`=0010 and `sel`=01, lasting 4 cycles, then `grant`=0010 again if `req[1]` is still 1.
- Idle return: during `grant`=1000, set `req`=0000. Expect `grant`=0000 and `busy`=0 at the next edge, `sel` held at 11, and `out_valid`=0 one cycle later.
- Reset mid-operation: with `req`=1111 and `grant`=0100 in cycle 2 of its tenure, pulse `rst`=0 between edges. Expect outputs to clear immediately. After release expect `grant`=0001 first, confirming `ptr` was reset.
